hyperram_responder: RTL and testbench

//  Synthesizable HyperRAM device-side responder (target end of the HyperRAM bus driven by hyperram_controller).

---
 rtl/hyperram_responder_pkg.sv | 45 ++++
 rtl/hyperram_responder_if.sv | 26 ++
 rtl/hyperram_responder_mem.sv | 39 +++
 rtl/hyperram_responder.sv | 234 +++++++++++++++++++++++
 tb/tb_hyperram_responder.sv | 225 ++++++++++++++++++++++
 5 files changed

// File: rtl/hyperram_responder_pkg.sv
// Shared definitions for the HyperRAM device-side responder: command/address (CA) field
// positions, register-space addresses, register reset values, FSM state encoding and small
// helpers for address advance and byte-enable merging.
package hyperram_responder_pkg;

  // CA word field positions (48-bit CA, MSB byte first on the bus)
  localparam int unsigned CaRwBit    = 47;  // 1 = read
  localparam int unsigned CaRegBit   = 46;  // 1 = register space
  localparam int unsigned CaBurstBit = 45;  // 1 = linear, 0 = wrapped 16-word group

  // Register-space word addresses
  localparam logic [31:0] RegId0 = 32'h0000_0000;
  localparam logic [31:0] RegId1 = 32'h0000_0001;
  localparam logic [31:0] RegCr0 = 32'h0000_0800;
  localparam logic [31:0] RegCr1 = 32'h0000_0801;

  // Configuration register reset values
  localparam logic [15:0] Cr0Reset = 16'h8F1F;
  localparam logic [15:0] Cr1Reset = 16'hFFC1;

  typedef enum logic [2:0] {
    StIdle,
    StCa,
    StLat,
    StWdata,
    StRdata
  } state_e;

  // Linear bursts run through the whole address space (the RAM uses the low bits, giving the
  // modulo-MemWords wrap); wrapped bursts stay inside their aligned 16-word group.
  function automatic logic [31:0] next_addr(input logic [31:0] addr, input logic linear);
    if (linear) begin
      return addr + 32'd1;
    end
    return {addr[31:4], addr[3:0] + 4'd1};
  endfunction

  function automatic logic [15:0] apply_be(input logic [15:0] old_val,
                                           input logic [15:0] new_val,
                                           input logic [1:0]  be);
    return {be[1] ? new_val[15:8] : old_val[15:8],
            be[0] ? new_val[7:0]  : old_val[7:0]};
  endfunction

endpackage

// File: rtl/hyperram_responder_if.sv
// HyperRAM bus as seen between the controller (master) and this responder (slave).
//   dram_ck, dram_cs_l, dram_rst_l      controller -> device clock, chip select, device reset
//   dram_dq_in, dram_rwds_in            controller -> device data and write byte mask
//   dram_dq_out, dram_dq_oe_l           device -> controller read data and its enable (active low)
//   dram_rwds_out, dram_rwds_oe_l       device -> controller latency flag / read strobe and enable
interface hyperram_responder_if;
  logic       dram_ck;
  logic       dram_cs_l;
  logic       dram_rst_l;
  logic [7:0] dram_dq_in;
  logic [7:0] dram_dq_out;
  logic       dram_dq_oe_l;
  logic       dram_rwds_in;
  logic       dram_rwds_out;
  logic       dram_rwds_oe_l;

  modport master (
    output dram_ck, dram_cs_l, dram_rst_l, dram_dq_in, dram_rwds_in,
    input  dram_dq_out, dram_dq_oe_l, dram_rwds_out, dram_rwds_oe_l
  );

  modport slave (
    input  dram_ck, dram_cs_l, dram_rst_l, dram_dq_in, dram_rwds_in,
    output dram_dq_out, dram_dq_oe_l, dram_rwds_out, dram_rwds_oe_l
  );
endinterface

// File: rtl/hyperram_responder_mem.sv
// Single-port synchronous backing RAM, Words x 16 bits, two byte enables, 1-cycle read latency.
// Contents are not reset.
//   clk_i    system clock
//   en_i     access enable (read when we_i = 0)
//   we_i     write enable
//   be_i     byte enables, [1] = bits 15:8, [0] = bits 7:0
//   addr_i   word address
//   wdata_i  write data
//   rdata_o  read data, valid the cycle after a read access, held otherwise
module hyperram_responder_mem #(
  parameter int unsigned Words = 1024,
  parameter int unsigned AddrW = $clog2(Words)
) (
  input  logic             clk_i,
  input  logic             en_i,
  input  logic             we_i,
  input  logic [1:0]       be_i,
  input  logic [AddrW-1:0] addr_i,
  input  logic [15:0]      wdata_i,
  output logic [15:0]      rdata_o
);

  logic [15:0] mem_q [Words];
  logic [15:0] rdata_q;

  always_ff @(posedge clk_i) begin
    if (en_i) begin
      if (we_i) begin
        if (be_i[1]) mem_q[addr_i][15:8] <= wdata_i[15:8];
        if (be_i[0]) mem_q[addr_i][7:0]  <= wdata_i[7:0];
      end else begin
        rdata_q <= mem_q[addr_i];
      end
    end
  end

  assign rdata_o = rdata_q;

endmodule

// File: rtl/hyperram_responder.sv
// HyperRAM device-side responder used as an on-chip loopback target for the controller.
// dram_ck is oversampled on clk_i (clk_i must be >= 4x dram_ck); every rise and fall of dram_ck
// is one DDR edge and all bus actions happen in the clk_i cycle that sees the edge.
// Reads/writes are served from an internal 16-bit RAM, or from the ID/CR registers in register
// space. Latency is fixed 2x: 4*LatencyCk edges after CA (LatencyCk must be >= 1); register
// writes have zero latency.
//   clk_i      system clock
//   rstn_i     synchronous active-low reset (dram_rst_l low has the same effect)
//   bus        HyperRAM bus, slave side
//   busy_o     high while chip select is low and a transaction is in progress
//   err_cnt_o  saturating count of chip-select deassertions during CA or latency
// Build option: define HRAM_RESP_ERRCNT_EN to enable the protocol-violation counter; without it
// err_cnt_o is tied to zero.
module hyperram_responder
  import hyperram_responder_pkg::*;
#(
  parameter int unsigned MemWords  = 1024,
  parameter int unsigned LatencyCk = 6,
  parameter logic [15:0] Id0Val    = 16'h0C81,
  parameter logic [15:0] Id1Val    = 16'h0001
) (
  input  logic                      clk_i,
  input  logic                      rstn_i,
  hyperram_responder_if.slave       bus,
  output logic                      busy_o,
  output logic [7:0]                err_cnt_o
);

  localparam int unsigned AddrW    = $clog2(MemWords);
  localparam logic [7:0]  LatEdges = 8'(4 * LatencyCk);

  state_e      state_q;
  logic        ck_q, cs_q;
  logic [39:0] ca_q;
  logic [2:0]  ca_cnt_q;
  logic [31:0] addr_q;
  logic        is_read_q, is_reg_q, linear_q;
  logic [7:0]  lat_cnt_q;
  logic        hi_phase_q;   // next data edge carries the upper byte
  logic [7:0]  hold_q;       // write: pending upper byte; read: pending lower byte
  logic        hold_mask_q;  // mask sampled with the pending upper write byte
  logic        reg_done_q;   // only the first word of a register write is used
  logic [15:0] cr0_q, cr1_q;
  logic [7:0]  dq_out_q;
  logic        dq_oe_l_q, rwds_out_q, rwds_oe_l_q;

  logic        rst, ck_edge, cs_high, cs_fall;
  logic [47:0] ca_full;
  logic [31:0] ca_addr;
  logic        unused_ca;
  logic [15:0] reg_rdata, rd_word, wr_word;
  logic [1:0]  wr_be;
  logic        mem_en, mem_we;
  logic [15:0] mem_rdata;

  assign rst     = ~rstn_i | ~bus.dram_rst_l;
  assign ck_edge = bus.dram_ck != ck_q;
  assign cs_high = bus.dram_cs_l;
  // Fall detection, so a reset released while cs_l is already low does not start a transaction.
  assign cs_fall = cs_q & ~bus.dram_cs_l;

  assign ca_full   = {ca_q, bus.dram_dq_in};
  assign ca_addr   = {ca_full[44:16], ca_full[2:0]};
  assign unused_ca = ^ca_full[15:3];

  always_comb begin
    reg_rdata = 16'h0000;
    case (addr_q)
      RegId0:  reg_rdata = Id0Val;
      RegId1:  reg_rdata = Id1Val;
      RegCr0:  reg_rdata = cr0_q;
      RegCr1:  reg_rdata = cr1_q;
      default: reg_rdata = 16'h0000;
    endcase
  end

  assign rd_word = is_reg_q ? reg_rdata : mem_rdata;
  assign wr_word = {hold_q, bus.dram_dq_in};
  assign wr_be   = ~{hold_mask_q, bus.dram_rwds_in};

  // The RAM reads addr_q continuously through latency and read data, so the first word is ready
  // when data starts and each following word is fetched right after the upper byte advances addr.
  assign mem_we = ~rst & ~cs_high & ck_edge & (state_q == StWdata) & ~hi_phase_q & ~is_reg_q;
  assign mem_en = mem_we | (state_q == StLat) | (state_q == StRdata);

  hyperram_responder_mem #(
    .Words (MemWords),
    .AddrW (AddrW)
  ) u_mem (
    .clk_i   (clk_i),
    .en_i    (mem_en),
    .we_i    (mem_we),
    .be_i    (wr_be),
    .addr_i  (addr_q[AddrW-1:0]),
    .wdata_i (wr_word),
    .rdata_o (mem_rdata)
  );

  // Bus history flops run through reset so no spurious edge is seen afterwards.
  always_ff @(posedge clk_i) begin
    ck_q <= bus.dram_ck;
    cs_q <= bus.dram_cs_l;
  end

  always_ff @(posedge clk_i) begin
    if (rst) begin
      state_q     <= StIdle;
      ca_q        <= '0;
      ca_cnt_q    <= '0;
      addr_q      <= '0;
      is_read_q   <= 1'b0;
      is_reg_q    <= 1'b0;
      linear_q    <= 1'b0;
      lat_cnt_q   <= '0;
      hi_phase_q  <= 1'b1;
      hold_q      <= '0;
      hold_mask_q <= 1'b0;
      reg_done_q  <= 1'b0;
      cr0_q       <= Cr0Reset;
      cr1_q       <= Cr1Reset;
      dq_out_q    <= '0;
      dq_oe_l_q   <= 1'b1;
      rwds_out_q  <= 1'b0;
      rwds_oe_l_q <= 1'b1;
    end else if (cs_high) begin
      // Chip select high ends everything at once; a half-received write word is dropped.
      state_q     <= StIdle;
      dq_oe_l_q   <= 1'b1;
      rwds_oe_l_q <= 1'b1;
    end else begin
      unique case (state_q)
        StIdle: begin
          if (cs_fall) begin
            state_q     <= StCa;
            ca_cnt_q    <= '0;
            rwds_out_q  <= 1'b1;  // signal 2x latency for the whole CA phase
            rwds_oe_l_q <= 1'b0;
          end
        end
        StCa: begin
          if (ck_edge) begin
            ca_q     <= ca_full[39:0];
            ca_cnt_q <= ca_cnt_q + 3'd1;
            if (ca_cnt_q == 3'd5) begin
              rwds_oe_l_q <= 1'b1;
              rwds_out_q  <= 1'b0;
              is_read_q   <= ca_full[CaRwBit];
              is_reg_q    <= ca_full[CaRegBit];
              linear_q    <= ca_full[CaBurstBit];
              addr_q      <= ca_addr;
              hi_phase_q  <= 1'b1;
              reg_done_q  <= 1'b0;
              lat_cnt_q   <= LatEdges;
              if (!ca_full[CaRwBit] && ca_full[CaRegBit]) begin
                state_q <= StWdata;
              end else begin
                state_q <= StLat;
              end
            end
          end
        end
        StLat: begin
          if (ck_edge) begin
            lat_cnt_q <= lat_cnt_q - 8'd1;
            if (lat_cnt_q == 8'd1) begin
              if (is_read_q) begin
                state_q     <= StRdata;
                dq_oe_l_q   <= 1'b0;
                rwds_oe_l_q <= 1'b0;
                rwds_out_q  <= 1'b0;
              end else begin
                state_q <= StWdata;
              end
            end
          end
        end
        StWdata: begin
          if (ck_edge) begin
            hi_phase_q <= ~hi_phase_q;
            if (hi_phase_q) begin
              hold_q      <= bus.dram_dq_in;
              hold_mask_q <= bus.dram_rwds_in;
            end else begin
              addr_q <= next_addr(addr_q, linear_q);
              if (is_reg_q && !reg_done_q) begin
                reg_done_q <= 1'b1;
                if (addr_q == RegCr0) cr0_q <= apply_be(cr0_q, wr_word, wr_be);
                if (addr_q == RegCr1) cr1_q <= apply_be(cr1_q, wr_word, wr_be);
              end
            end
          end
        end
        StRdata: begin
          if (ck_edge) begin
            hi_phase_q <= ~hi_phase_q;
            if (hi_phase_q) begin
              dq_out_q   <= rd_word[15:8];
              hold_q     <= rd_word[7:0];
              rwds_out_q <= 1'b1;
              addr_q     <= next_addr(addr_q, linear_q);
            end else begin
              dq_out_q   <= hold_q;
              rwds_out_q <= 1'b0;
            end
          end
        end
        default: state_q <= StIdle;
      endcase
    end
  end

`ifdef HRAM_RESP_ERRCNT_EN
  logic [7:0] err_cnt_q;

  always_ff @(posedge clk_i) begin
    if (rst) begin
      err_cnt_q <= '0;
    end else if (cs_high && (state_q == StCa || state_q == StLat) && err_cnt_q != 8'hFF) begin
      err_cnt_q <= err_cnt_q + 8'd1;
    end
  end

  assign err_cnt_o = err_cnt_q;
`else
  assign err_cnt_o = 8'h00;
`endif

  assign busy_o             = ~bus.dram_cs_l & (state_q != StIdle);
  assign bus.dram_dq_out    = dq_out_q;
  assign bus.dram_dq_oe_l   = dq_oe_l_q;
  assign bus.dram_rwds_out  = rwds_out_q;
  assign bus.dram_rwds_oe_l = rwds_oe_l_q;

endmodule

// File: tb/tb_hyperram_responder.sv
// Directed bench for hyperram_responder: the bench plays the controller, read data expectations
// are queued when a read is set up and popped as each word comes back.
module tb_hyperram_responder;

  localparam int Lat = 6;

  logic       clk;
  logic       rstn;
  logic       busy;
  logic [7:0] err_cnt;

  hyperram_responder_if bus_if ();

  hyperram_responder #(
    .MemWords  (1024),
    .LatencyCk (Lat),
    .Id0Val    (16'h0C81),
    .Id1Val    (16'h0001)
  ) dut (
    .clk_i     (clk),
    .rstn_i    (rstn),
    .bus       (bus_if.slave),
    .busy_o    (busy),
    .err_cnt_o (err_cnt)
  );

  int          n_vec;
  int          n_fail;
  logic [15:0] exp_q [$];
  logic [15:0] wbuf [16];
  logic [1:0]  mbuf [16];
  logic [7:0]  exp_err;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "time limit");
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // One DDR edge: toggle ck with new input data, then sample outputs one clk later.
  task automatic bus_edge(input logic [7:0] dq, input logic rwds,
                          output logic [7:0] dq_o, output logic rwds_o);
    @(negedge clk);
    bus_if.dram_ck      = ~bus_if.dram_ck;
    bus_if.dram_dq_in   = dq;
    bus_if.dram_rwds_in = rwds;
    @(negedge clk);
    dq_o   = bus_if.dram_dq_out;
    rwds_o = bus_if.dram_rwds_out;
  endtask

  task automatic pop_check(input logic [7:0] hi, input logic [7:0] lo,
                           input logic r1, input logic r0);
    logic [15:0] e;
    if (exp_q.size() == 0) begin
      n_vec++;
      n_fail++;
      $error("FAIL rd_data: observed %h expected nothing queued", {hi, lo});
    end else begin
      e = exp_q.pop_front();
      check("rd_data", 32'({hi, lo}), 32'(e));
      check("rd_rwds", 32'({r1, r0}), 32'd2);
    end
  endtask

  function automatic logic [47:0] make_ca(input logic rd, input logic regsp, input logic lin,
                                          input logic [31:0] a);
    return {rd, regsp, lin, a[31:3], 13'h0, a[2:0]};
  endfunction

  task automatic start_ca(input logic [47:0] ca, input int n_bytes);
    logic [7:0] d;
    logic       r;
    @(negedge clk);
    bus_if.dram_cs_l = 1'b0;
    @(negedge clk);
    check("ca_rwds_oe", 32'(bus_if.dram_rwds_oe_l), 32'd0);
    check("ca_rwds", 32'(bus_if.dram_rwds_out), 32'd1);
    for (int i = 0; i < n_bytes; i++) bus_edge(ca[47-8*i -: 8], 1'b0, d, r);
  endtask

  task automatic txn(input logic rd, input logic regsp, input logic lin,
                     input logic [31:0] a, input int n);
    logic [7:0] hi, lo;
    logic       r1, r0;
    start_ca(make_ca(rd, regsp, lin, a), 6);
    check("ca_end_rwds_oe", 32'(bus_if.dram_rwds_oe_l), 32'd1);
    if (rd || !regsp) begin
      for (int i = 0; i < 4 * Lat; i++) bus_edge(8'h00, 1'b0, hi, r1);
    end
    for (int w = 0; w < n; w++) begin
      if (rd) begin
        bus_edge(8'h00, 1'b0, hi, r1);
        if (w == 0) check("rd_dq_oe", 32'(bus_if.dram_dq_oe_l), 32'd0);
        bus_edge(8'h00, 1'b0, lo, r0);
        pop_check(hi, lo, r1, r0);
      end else begin
        bus_edge(wbuf[w][15:8], mbuf[w][1], hi, r1);
        bus_edge(wbuf[w][7:0], mbuf[w][0], lo, r0);
      end
    end
    @(negedge clk);
    bus_if.dram_cs_l = 1'b1;
    @(negedge clk);
    check("end_dq_oe", 32'(bus_if.dram_dq_oe_l), 32'd1);
    check("end_busy", 32'(busy), 32'd0);
  endtask

  task automatic clear_mask();
    for (int i = 0; i < 16; i++) mbuf[i] = 2'b00;
  endtask

  initial begin
    logic [7:0] hi, lo;
    logic       r1, r0;
    n_vec  = 0;
    n_fail = 0;
`ifdef HRAM_RESP_ERRCNT_EN
    exp_err = 8'd1;
`else
    exp_err = 8'd0;
`endif
    rstn                  = 1'b0;
    bus_if.dram_ck        = 1'b0;
    bus_if.dram_cs_l      = 1'b1;
    bus_if.dram_rst_l     = 1'b1;
    bus_if.dram_dq_in     = 8'h00;
    bus_if.dram_rwds_in   = 1'b0;
    clear_mask();
    repeat (3) @(negedge clk);
    check("rst_dq_oe", 32'(bus_if.dram_dq_oe_l), 32'd1);
    check("rst_rwds_oe", 32'(bus_if.dram_rwds_oe_l), 32'd1);
    check("rst_dq_out", 32'(bus_if.dram_dq_out), 32'd0);
    check("rst_rwds_out", 32'(bus_if.dram_rwds_out), 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_err_cnt", 32'(err_cnt), 32'd0);
    rstn = 1'b1;
    repeat (2) @(negedge clk);

    // Linear write of four words at 0x10, then read back
    wbuf[0] = 16'h1111; wbuf[1] = 16'h2222; wbuf[2] = 16'h3333; wbuf[3] = 16'h4444;
    txn(1'b0, 1'b0, 1'b1, 32'h10, 4);
    exp_q.push_back(16'h1111); exp_q.push_back(16'h2222);
    exp_q.push_back(16'h3333); exp_q.push_back(16'h4444);
    txn(1'b1, 1'b0, 1'b1, 32'h10, 4);

    // Byte-masked write: lower byte masked keeps the earlier 0x55
    wbuf[0] = 16'h5555;
    txn(1'b0, 1'b0, 1'b1, 32'h20, 1);
    wbuf[0] = 16'hABCD;
    mbuf[0] = 2'b01;
    txn(1'b0, 1'b0, 1'b1, 32'h20, 1);
    clear_mask();
    exp_q.push_back(16'hAB55);
    txn(1'b1, 1'b0, 1'b1, 32'h20, 1);

    // Wrapped read across the 16-word group boundary
    for (int i = 0; i < 16; i++) wbuf[i] = 16'(i);
    txn(1'b0, 1'b0, 1'b1, 32'h0, 16);
    exp_q.push_back(16'h000E); exp_q.push_back(16'h000F);
    exp_q.push_back(16'h0000); exp_q.push_back(16'h0001);
    txn(1'b1, 1'b0, 1'b0, 32'h0E, 4);

    // Register space: ID reads, CR0 reset value, zero-latency CR0 write
    exp_q.push_back(16'h0C81); exp_q.push_back(16'h0001);
    txn(1'b1, 1'b1, 1'b1, 32'h0, 2);
    exp_q.push_back(16'h8F1F);
    txn(1'b1, 1'b1, 1'b1, 32'h800, 1);
    wbuf[0] = 16'h8F17;
    txn(1'b0, 1'b1, 1'b1, 32'h800, 1);
    exp_q.push_back(16'h8F17);
    txn(1'b1, 1'b1, 1'b1, 32'h800, 1);

    // Chip select released after three CA bytes
    start_ca(make_ca(1'b1, 1'b0, 1'b1, 32'h10), 3);
    @(negedge clk);
    bus_if.dram_cs_l = 1'b1;
    @(negedge clk);
    check("abort_dq_oe", 32'(bus_if.dram_dq_oe_l), 32'd1);
    check("abort_rwds_oe", 32'(bus_if.dram_rwds_oe_l), 32'd1);
    check("abort_busy", 32'(busy), 32'd0);
    check("abort_err_cnt", 32'(err_cnt), 32'(exp_err));
    bus_edge(8'h00, 1'b0, hi, r1);  // return ck low while idle

    // Reset pulse in the middle of a read burst
    exp_q.push_back(16'h1111);
    start_ca(make_ca(1'b1, 1'b0, 1'b1, 32'h10), 6);
    for (int i = 0; i < 4 * Lat; i++) bus_edge(8'h00, 1'b0, hi, r1);
    bus_edge(8'h00, 1'b0, hi, r1);
    bus_edge(8'h00, 1'b0, lo, r0);
    pop_check(hi, lo, r1, r0);
    bus_edge(8'h00, 1'b0, hi, r1);
    check("mid_hi_byte", 32'(hi), 32'h22);
    @(negedge clk);
    rstn = 1'b0;
    @(negedge clk);
    check("mid_rst_dq_oe", 32'(bus_if.dram_dq_oe_l), 32'd1);
    check("mid_rst_busy", 32'(busy), 32'd0);
    check("mid_rst_err_cnt", 32'(err_cnt), 32'd0);
    rstn = 1'b1;
    @(negedge clk);
    check("post_rst_busy", 32'(busy), 32'd0);
    bus_if.dram_cs_l = 1'b1;
    bus_edge(8'h00, 1'b0, hi, r1);  // odd edge count so far; return ck low
    exp_q.push_back(16'h1111); exp_q.push_back(16'h2222);
    exp_q.push_back(16'h3333); exp_q.push_back(16'h4444);
    txn(1'b1, 1'b0, 1'b1, 32'h10, 4);

    check("queue_empty", 32'(exp_q.size()), 32'd0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
    $finish;
  end

endmodule
